mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide unit with its sequencer. It sits in the E stage beside the ALU and is driven by the E-stage controller's `enMDU`/`MDUOp` outputs. It owns HI/LO, runs mult/div ops over a fixed number of cycles, and exposes `busy` to the hazard unit so dependent MDU instructions stall. It also returns HI/LO for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd/maddu/msub/msubu. Legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu. Legal range 1–15.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  E-stage `enMDU`.
- `op`  in  4  E-stage `MDUOp`.
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `kill`  in  1  E-stage instruction is cancelled (exception/interrupt); blocks `start` this cycle.
- `busy`  out  1  registered; an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `rdata`  out  32  combinational: `hi` if `op`=MFHI, `lo` if `op`=MFLO, else 0.

## Operation
- State machine states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, 4-bit down-counter `cnt` active.
- Accept rule: in IDLE with `start`=1, `kill`=0:
  - MULT/MULTU/MADD/MADDU/MSUB/MSUBU: latch the 64-bit result into `res` and set `cnt`=MULT_CYCLES-1 → RUN.
  - DIV/DIVU: latch the result into `res` and set `cnt`=DIV_CYCLES-1 → RUN.
  - MTHI/MTLO: write `a` into HI/LO at the same edge and stay in IDLE.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned 32×32→64. Result {HI,LO}.
  - DIV/DIVU: LO=quotient, HI=remainder. Signed division truncates toward zero and the remainder takes the dividend's sign.
  - MADD/MSUB: {HI,LO} ± signed a*b. MADDU/MSUBU: {HI,LO} ± unsigned a*b. Mod 2^64, using the HI/LO values at accept time.
- RUN: `cnt` decrements each cycle. At `cnt`=0: {HI,LO}←`res` → IDLE.
- Divide by zero (`b`=0): the full DIV timing runs but HI/LO stay unchanged at completion.
- `start` while RUN: ignored (the hazard unit guarantees this cannot happen legally).
- `kill` affects only the accept cycle. An accepted op always completes.
- `reset` (any time, including mid-RUN): IDLE, `busy`=0, `cnt`=0, `res`=0, HI=0, LO=0.
- MFHI/MFLO and op=0: no state change.

## Timing
- Reset values:
  - `busy`=0, `hi`=0, `lo`=0.
  - `rdata`=0 unless `op` selects HI/LO.
- Latency: accept in cycle 0, `busy`=1 in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES). HI/LO are updated at the edge ending cycle N and `busy`=0 in cycle N+1.
- A mfhi in cycle N+1 reads the new value. The hazard unit stalls D on (`start` | `busy`) when the D-stage instruction uses the MDU.
- MTHI/MTLO: new value visible the cycle after accept. No busy.
- `rdata` during RUN returns the old HI/LO.
- Back-to-back ops: a new `start` is accepted in cycle N+1.

## Configuration
- `MDU_MADD_EN` defined: MADD/MADDU/MSUB/MSUBU are implemented as above.
- `MDU_MADD_EN` undefined: those four opcodes are treated as no-ops. No accept, `busy` stays 0, HI/LO unchanged, and no accumulate adder is synthesised.

## Structure
- Shared package `const.v` holds the MDUOp encodings: MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
- `const.v` also holds the state encodings IDLE=0, RUN=1.
- One sub-module, `mdu_calc`: purely combinational. Inputs `op`, `a`, `b`, `hi`, `lo`; outputs the 64-bit result and a `dz` flag.
- The sequencer (FSM, counter, HI/LO, `res`) stays in `mdu_sequencer`.

## Test plan
- MULT a=3, b=0xFFFFFFFE → `busy` high exactly cycles 1–5. Cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU a=7, b=2 → `busy` high for 10 cycles, then lo=3, hi=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV with b=0 → 10 busy cycles, then HI/LO unchanged.
- MTLO 0xFFFFFFFF then MADDU a=1, b=1 (hi=0) → lo=0, hi=1. Without MDU_MADD_EN → `busy` stays 0 and hi=0, lo=0xFFFFFFFF.
- Interruption cases:
  - MULT with `kill`=1 → no busy and HI/LO unchanged.
  - MULT started, `start` reasserted in cycle 2 → ignored.
  - `reset` in cycle 3 of DIV → busy=0, hi=lo=0 immediately.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU opcode and sequencer state encodings for mdu_sequencer and mdu_calc.
package mdu_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: 64-bit product/quotient result and divide-by-zero flag.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) exist only when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        dz
);

  logic [63:0] sa, sb, sprod, uprod;
  logic [31:0] bs, sq, sr, uq, ur;

  assign sa    = {{32{a[31]}}, a};
  assign sb    = {{32{b[31]}}, b};
  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign sprod = sa * sb;
  assign uprod = {32'd0, a} * {32'd0, b};

  // Substitute divisor keeps the dividers X-free; the result is discarded when b==0.
  assign bs = (b == '0) ? 32'd1 : b;
  assign sq = $signed(a) / $signed(bs);
  assign sr = $signed(a) % $signed(bs);
  assign uq = a / bs;
  assign ur = a % bs;

  always_comb begin
    res = {hi, lo};
    dz  = 1'b0;
    case (mdu_op_e'(op))
      OP_MULT:  res = sprod;
      OP_MULTU: res = uprod;
      OP_DIV: begin
        res = {sr, sq};
        dz  = (b == '0);
      end
      OP_DIVU: begin
        res = {ur, uq};
        dz  = (b == '0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi, lo} + sprod;
      OP_MADDU: res = {hi, lo} + uprod;
      OP_MSUB:  res = {hi, lo} - sprod;
      OP_MSUBU: res = {hi, lo} - uprod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; busy stalls dependent MDU ops.
// Optional MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] calc_res;
  logic        calc_dz;
  logic        is_mult, is_div;
  mdu_op_e     op_e;

  mdu_calc u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc_res),
    .dz  (calc_dz)
  );

  assign op_e    = mdu_op_e'(op);
  assign is_div  = (op_e == OP_DIV) || (op_e == OP_DIVU);
`ifdef MDU_MADD_EN
  assign is_mult = (op_e == OP_MULT) || (op_e == OP_MULTU) || (op_e == OP_MADD) ||
                   (op_e == OP_MADDU) || (op_e == OP_MSUB) || (op_e == OP_MSUBU);
`else
  assign is_mult = (op_e == OP_MULT) || (op_e == OP_MULTU);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          if (is_mult) begin
            res_d   = calc_res;
            cnt_d   = MULT_CNT;
            state_d = RUN;
          end else if (is_div) begin
            // A zero divisor commits the current HI/LO back, leaving them unchanged.
            res_d   = calc_dz ? {hi_q, lo_q} : calc_res;
            cnt_d   = DIV_CNT;
            state_d = RUN;
          end else if (op_e == OP_MTHI) begin
            hi_d = a;
          end else if (op_e == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = res_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (op_e == OP_MFHI) ? hi_q :
                 (op_e == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_sequencer;

  localparam logic [3:0] MULT  = 4'd1, MULTU = 4'd2, DIV  = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5, MFLO  = 4'd6, MTHI = 4'd7, MTLO = 4'd8;
  localparam logic [3:0] MADDU = 4'd10;
  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  mdu_sequencer #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0; op = 4'd0; a = '0; b = '0;
  endtask

  task automatic check_hilo(input string name);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL %s: hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    else passed++;
  endtask

  task automatic check_busy_window(input string name, input int n);
    for (int i = 1; i <= n; i++) begin
      checks++;
      if (busy !== 1'b1) $display("FAIL %s_busy cycle %0d: got %b want 1", name, i, busy);
      else passed++;
      step();
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_done: busy=%b want 0", name, busy);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    op = MFHI;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0 || rdata !== '0)
      $display("FAIL reset: busy=%b hi=%h lo=%h rdata=%h want 0", busy, hi, lo, rdata);
    else passed++;
    op = 4'd0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    issue(MULT, 32'd3, 32'hFFFF_FFFE);
    check_busy_window("mult", NM);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
    check_hilo("mult");
    op = MFHI; #1;
    checks++;
    if (rdata !== 32'hFFFF_FFFF) $display("FAIL mfhi: got %h want ffffffff", rdata);
    else passed++;
    op = MFLO; #1;
    checks++;
    if (rdata !== 32'hFFFF_FFFA) $display("FAIL mflo: got %h want fffffffa", rdata);
    else passed++;
    op = 4'd0;
    step();
  endtask

  task automatic test_mthi_mtlo_madd();
    issue(MTHI, 32'd0, 32'd0);
    issue(MTLO, 32'hFFFF_FFFF, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'hFFFF_FFFF;
    checks++;
    if (busy !== 1'b0) $display("FAIL mt_busy: got %b want 0", busy);
    else passed++;
    check_hilo("mthi_mtlo");
    issue(MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check_busy_window("maddu", NM);
    exp_hi = 32'd1; exp_lo = 32'd0;
`else
    for (int i = 1; i <= NM + 1; i++) begin
      checks++;
      if (busy !== 1'b0) $display("FAIL maddu_noop_busy cycle %0d: got %b want 0", i, busy);
      else passed++;
      step();
    end
`endif
    check_hilo("maddu");
  endtask

  task automatic test_divu();
    logic [31:0] old_lo;
    old_lo = exp_lo;
    issue(DIVU, 32'd7, 32'd2);
    step();
    op = MFLO; #1;
    checks++;
    if (rdata !== old_lo) $display("FAIL rdata_during_run: got %h want %h", rdata, old_lo);
    else passed++;
    op = 4'd0;
    // first busy cycle consumed above; check the remaining ones
    check_busy_window("divu", ND - 1);
    exp_hi = 32'd1; exp_lo = 32'd3;
    check_hilo("divu");
  endtask

  task automatic test_div_signed();
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    check_busy_window("div", ND);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
    check_hilo("div_signed");
  endtask

  task automatic test_div_zero();
    issue(DIV, 32'd5, 32'd0);
    check_busy_window("div0", ND);
    check_hilo("div_zero");
  endtask

  task automatic test_kill();
    kill = 1'b1;
    issue(MULT, 32'd2, 32'd2);
    kill = 1'b0;
    for (int i = 1; i <= NM + 1; i++) begin
      checks++;
      if (busy !== 1'b0) $display("FAIL kill_busy cycle %0d: got %b want 0", i, busy);
      else passed++;
      step();
    end
    check_hilo("kill");
  endtask

  task automatic test_start_ignored();
    issue(MULT, 32'd5, 32'd6);
    step();
    issue(MULTU, 32'd2, 32'd2);
    check_busy_window("reassert", NM - 2);
    exp_hi = 32'd0; exp_lo = 32'd30;
    check_hilo("start_ignored");
    step();
    checks++;
    if (busy !== 1'b0) $display("FAIL reassert_after: busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_busy_window("b2b_first", NM);
    exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h0000_0001;
    check_hilo("b2b_first");
    issue(DIVU, 32'd100, 32'd7);
    check_busy_window("b2b_second", ND);
    exp_hi = 32'd2; exp_lo = 32'd14;
    check_hilo("b2b_second");
  endtask

  task automatic test_reset_mid_div();
    issue(DIVU, 32'd9, 32'd4);
    step();
    step();
    reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", busy);
    else passed++;
    check_hilo("reset_mid");
    step();
    reset = 1'b0;
    for (int i = 1; i <= ND; i++) step();
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_mid_after: busy=%b want 0", busy);
    else passed++;
    check_hilo("reset_mid_after");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mthi_mtlo_madd();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_kill();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
